pcs_link_ctrl: RTL

PCS_LINK_CTRL -- requirements
Module: pcs_link_ctrl

---
 rtl/pcs_link_ctrl_if.sv | 27 ++
 rtl/pcs_link_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/pcs_link_ctrl_if.sv
// Link-control signal bundle between the PCS synchronization block and the link controller.
// The controller uses the slave modport; the sync-block side uses master.
interface pcs_link_ctrl_if;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 8;

  logic               signal_detect;
  logic               code_sync_status;
  logic               rx_even;
  logic               mr_loopback_req;
  logic               sync_reset;
  logic               mr_loopback;
  logic               link_ok;
  logic [STATE_W-1:0] link_state;
  logic [CNT_W-1:0]   sync_loss_cnt;
  logic [CNT_W-1:0]   restart_cnt;

  modport master (
    output signal_detect, code_sync_status, rx_even, mr_loopback_req,
    input  sync_reset, mr_loopback, link_ok, link_state, sync_loss_cnt, restart_cnt
  );

  modport slave (
    input  signal_detect, code_sync_status, rx_even, mr_loopback_req,
    output sync_reset, mr_loopback, link_ok, link_state, sync_loss_cnt, restart_cnt
  );
endinterface

// File: rtl/pcs_link_ctrl.sv
// PCS link controller: restarts the sync block, waits for signal, acquires code sync,
// confirms it for LINK_HOLD cycles on an even boundary and tracks loss/timeout counts.
module pcs_link_ctrl #(
  parameter int unsigned RESTART_LEN  = 4,
  parameter int unsigned SYNC_TIMEOUT = 32,
  parameter int unsigned LINK_HOLD    = 8
) (
  input  logic           clk,
  input  logic           mr_main_reset,
  pcs_link_ctrl_if.slave link
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned T_MAX0 = (RESTART_LEN > SYNC_TIMEOUT) ? RESTART_LEN : SYNC_TIMEOUT;
  localparam int unsigned T_MAX  = (T_MAX0 > LINK_HOLD) ? T_MAX0 : LINK_HOLD;
  localparam int unsigned TW     = (T_MAX < 2) ? 1 : $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    ST_RESTART     = 3'd0,
    ST_WAIT_SIGNAL = 3'd1,
    ST_ACQUIRE     = 3'd2,
    ST_CONFIRM     = 3'd3,
    ST_LINK_UP     = 3'd4
  } state_t;

  state_t           state;
  state_t           nxt_c;
  logic [TW-1:0]    timer;
  logic             sync_reset;
  logic             mr_loopback;
  logic             link_ok;
  logic [CNT_W-1:0] sync_loss_cnt;
  logic [CNT_W-1:0] restart_cnt;
  logic             sig_c;
  logic             lb_mis_c;
  logic             inc_loss_c;
  logic             inc_restart_c;
  logic             hold_done_c;

  assign sig_c       = link.signal_detect | mr_loopback;
  assign lb_mis_c    = link.mr_loopback_req != mr_loopback;
  assign hold_done_c = timer >= TW'(LINK_HOLD - 1);

  // Next state; loopback mismatch beats signal loss beats sync/timer conditions.
  always_comb begin
    nxt_c         = state;
    inc_loss_c    = 1'b0;
    inc_restart_c = 1'b0;
    if (state == ST_RESTART) begin
      if (timer == TW'(RESTART_LEN - 1)) nxt_c = ST_WAIT_SIGNAL;
    end else if (lb_mis_c) begin
      nxt_c = ST_RESTART;
    end else if (!sig_c) begin
      nxt_c      = ST_WAIT_SIGNAL;
      inc_loss_c = (state == ST_LINK_UP);
    end else begin
      case (state)
        ST_WAIT_SIGNAL: nxt_c = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (link.code_sync_status) begin
            nxt_c = ST_CONFIRM;
          end else if (timer == TW'(SYNC_TIMEOUT - 1)) begin
            nxt_c         = ST_RESTART;
            inc_restart_c = 1'b1;
          end
        end
        ST_CONFIRM: begin
          if (!link.code_sync_status)          nxt_c = ST_ACQUIRE;
          else if (hold_done_c && link.rx_even) nxt_c = ST_LINK_UP;
        end
        ST_LINK_UP: begin
          if (!link.code_sync_status) begin
            nxt_c      = ST_ACQUIRE;
            inc_loss_c = 1'b1;
          end
        end
        default: nxt_c = ST_RESTART;
      endcase
    end
  end

  // State, shared timer, registered outputs and saturating counters.
  always_ff @(posedge clk or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state         <= ST_RESTART;
      timer         <= '0;
      sync_reset    <= 1'b1;
      mr_loopback   <= 1'b0;
      link_ok       <= 1'b0;
      sync_loss_cnt <= '0;
      restart_cnt   <= '0;
    end else begin
      state      <= nxt_c;
      sync_reset <= (nxt_c == ST_RESTART);
      link_ok    <= (nxt_c == ST_LINK_UP);
      if (nxt_c != state)  timer <= '0;
      else if (timer != '1) timer <= timer + TW'(1);
      if (state == ST_RESTART) mr_loopback <= link.mr_loopback_req;
      if (inc_loss_c && sync_loss_cnt != '1)  sync_loss_cnt <= sync_loss_cnt + CNT_W'(1);
      if (inc_restart_c && restart_cnt != '1) restart_cnt   <= restart_cnt + CNT_W'(1);
    end
  end

  assign link.sync_reset    = sync_reset;
  assign link.mr_loopback   = mr_loopback;
  assign link.link_ok       = link_ok;
  assign link.link_state    = state;
  assign link.sync_loss_cnt = sync_loss_cnt;
  assign link.restart_cnt   = restart_cnt;

endmodule
